// File: rtl/joystick_scanner_if.sv
// DRP read port between joystick_scanner and the XADC wizard.
// The scanner is the master; the XADC side is the slave.
interface joystick_scanner_if;
    logic [6:0]  daddr;
    logic        den;
    logic        drdy;
    logic [15:0] do_data;

    modport master (
        output daddr,
        output den,
        input  drdy,
        input  do_data
    );

    modport slave (
        input  daddr,
        input  den,
        output drdy,
        output do_data
    );
endinterface

// File: rtl/joystick_scanner.sv
// XADC DRP read sequencer and two-player joystick direction decoder.
// Optional JOYSTICK_SCANNER_DEBOUNCE_EN: two-scan agreement per axis.
module joystick_scanner #(
    parameter logic [6:0]  CH0_ADDR       = 7'h16,
    parameter logic [6:0]  CH1_ADDR       = 7'h1E,
    parameter logic [6:0]  CH2_ADDR       = 7'h17,
    parameter logic [6:0]  CH3_ADDR       = 7'h1F,
    parameter logic [11:0] LO_ON          = 12'h400,
    parameter logic [11:0] LO_OFF         = 12'h600,
    parameter logic [11:0] HI_ON          = 12'hC00,
    parameter logic [11:0] HI_OFF         = 12'hA00,
    parameter int          TIMEOUT_CYCLES = 255
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               frame_tick,
    joystick_scanner_if.master drp,
    output logic               p1_up,
    output logic               p1_down,
    output logic               p1_left,
    output logic               p1_right,
    output logic               p2_up,
    output logic               p2_down,
    output logic               p2_left,
    output logic               p2_right,
    output logic               scan_done,
    output logic               timeout_err
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, UPDATE} state_t;

    state_t        state, state_nx;
    logic [1:0]    idx;
    logic [CW-1:0] cnt;
    logic [11:0]   smp;
    logic          smp_ok;
    logic [3:0]    lo_q, hi_q;
    logic          nx_lo, nx_hi;
    logic          unused_lsb;

    assign unused_lsb = ^drp.do_data[3:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        drp.den   = 1'b0;
        scan_done = 1'b0;
        unique case (state)
            IDLE:   if (frame_tick) state_nx = ISSUE;
            ISSUE: begin
                drp.den  = 1'b1;
                state_nx = WAIT;
            end
            WAIT:   if (drp.drdy || cnt == TO_LAST) state_nx = UPDATE;
            UPDATE: begin
                scan_done = (idx == 2'd3);
                state_nx  = (idx == 2'd3) ? IDLE : ISSUE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Address follows idx, which only moves on UPDATE, so it is stable
    // from ISSUE through WAIT.
    always_comb begin
        drp.daddr = CH0_ADDR;
        unique case (idx)
            2'd0: drp.daddr = CH0_ADDR;
            2'd1: drp.daddr = CH1_ADDR;
            2'd2: drp.daddr = CH2_ADDR;
            2'd3: drp.daddr = CH3_ADDR;
            default: drp.daddr = CH0_ADDR;
        endcase
    end

    // Hysteresis: set thresholds win over release thresholds and
    // force the opposite flag of the axis low.
    always_comb begin
        nx_lo = lo_q[idx];
        nx_hi = hi_q[idx];
        if (smp >= LO_OFF) nx_lo = 1'b0;
        if (smp <= HI_OFF) nx_hi = 1'b0;
        if (smp <= LO_ON) begin
            nx_lo = 1'b1;
            nx_hi = 1'b0;
        end
        if (smp >= HI_ON) begin
            nx_hi = 1'b1;
            nx_lo = 1'b0;
        end
    end

`ifdef JOYSTICK_SCANNER_DEBOUNCE_EN
    logic [3:0][1:0] pend_q;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx         <= 2'd0;
            cnt         <= '0;
            smp         <= '0;
            smp_ok      <= 1'b0;
            timeout_err <= 1'b0;
            lo_q        <= '0;
            hi_q        <= '0;
`ifdef JOYSTICK_SCANNER_DEBOUNCE_EN
            pend_q      <= '0;
`endif
        end else begin
            unique case (state)
                IDLE: if (frame_tick) idx <= 2'd0;
                ISSUE: begin
                    cnt    <= '0;
                    smp_ok <= 1'b0;
                end
                WAIT: begin
                    if (drp.drdy) begin
                        smp    <= drp.do_data[15:4];
                        smp_ok <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                        if (cnt == TO_LAST) timeout_err <= 1'b1;
                    end
                end
                UPDATE: begin
                    idx <= idx + 2'd1;
                    if (smp_ok) begin
`ifdef JOYSTICK_SCANNER_DEBOUNCE_EN
                        pend_q[idx] <= {nx_hi, nx_lo};
                        if (pend_q[idx] == {nx_hi, nx_lo}) begin
                            lo_q[idx] <= nx_lo;
                            hi_q[idx] <= nx_hi;
                        end
`else
                        lo_q[idx] <= nx_lo;
                        hi_q[idx] <= nx_hi;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign p1_up    = lo_q[0];
    assign p1_down  = hi_q[0];
    assign p1_left  = lo_q[1];
    assign p1_right = hi_q[1];
    assign p2_up    = lo_q[2];
    assign p2_down  = hi_q[2];
    assign p2_left  = lo_q[3];
    assign p2_right = hi_q[3];
endmodule

// File: tb/tb_joystick_scanner.sv
// Randomized bench for joystick_scanner with a behavioural axis model.
// Model follows JOYSTICK_SCANNER_DEBOUNCE_EN when it is defined.
module tb_joystick_scanner;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic frame_tick = 1'b0;
    logic p1_up, p1_down, p1_left, p1_right;
    logic p2_up, p2_down, p2_left, p2_right;
    logic scan_done, timeout_err;

    joystick_scanner_if drp();

    joystick_scanner dut (
        .clk(clk),
        .reset(reset),
        .frame_tick(frame_tick),
        .drp(drp.master),
        .p1_up(p1_up),
        .p1_down(p1_down),
        .p1_left(p1_left),
        .p1_right(p1_right),
        .p2_up(p2_up),
        .p2_down(p2_down),
        .p2_left(p2_left),
        .p2_right(p2_right),
        .scan_done(scan_done),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int done_cnt = 0;
    int den_cnt = 0;

    always @(negedge clk) begin
        if (scan_done) done_cnt++;
        if (drp.den) den_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: one lo/hi pair per channel plus debounce memory.
    bit       m_lo[4];
    bit       m_hi[4];
    bit [1:0] m_pend[4];
    bit       m_to;
    logic [6:0] addr_tab[4];

    logic [11:0] smp[4];
    int          dly[4];

    function automatic void model_reset();
        for (int i = 0; i < 4; i++) begin
            m_lo[i] = 0;
            m_hi[i] = 0;
            m_pend[i] = 0;
        end
        m_to = 0;
    endfunction

    function automatic void model_apply(int ch, logic [11:0] s);
        bit lo = m_lo[ch];
        bit hi = m_hi[ch];
        if (s <= 12'h400) begin
            lo = 1; hi = 0;
        end else if (s >= 12'hC00) begin
            hi = 1; lo = 0;
        end else begin
            if (s >= 12'h600) lo = 0;
            if (s <= 12'hA00) hi = 0;
        end
`ifdef JOYSTICK_SCANNER_DEBOUNCE_EN
        if (m_pend[ch] == {hi, lo}) begin
            m_lo[ch] = lo;
            m_hi[ch] = hi;
        end
        m_pend[ch] = {hi, lo};
`else
        m_lo[ch] = lo;
        m_hi[ch] = hi;
`endif
    endfunction

    task automatic check_flags(input string tag);
        chk({tag, ".p1_up"},    p1_up,    m_lo[0]);
        chk({tag, ".p1_down"},  p1_down,  m_hi[0]);
        chk({tag, ".p1_left"},  p1_left,  m_lo[1]);
        chk({tag, ".p1_right"}, p1_right, m_hi[1]);
        chk({tag, ".p2_up"},    p2_up,    m_lo[2]);
        chk({tag, ".p2_down"},  p2_down,  m_hi[2]);
        chk({tag, ".p2_left"},  p2_left,  m_lo[3]);
        chk({tag, ".p2_right"}, p2_right, m_hi[3]);
        chk({tag, ".timeout"},  timeout_err, m_to);
    endtask

    task automatic wait_den(input int bound, output bit ok);
        ok = 0;
        for (int i = 0; i < bound && !ok; i++) begin
            @(negedge clk);
            if (drp.den) ok = 1;
        end
    endtask

    task automatic respond(input int ch, input int d, input bit tick_mid);
        repeat (d) begin
            @(negedge clk);
            if (tick_mid) frame_tick = 1'b1;
        end
        drp.drdy = 1'b1;
        drp.do_data = {smp[ch], 4'($urandom)};
        frame_tick = 1'b0;
        @(negedge clk);
        drp.drdy = 1'b0;
        drp.do_data = 16'($urandom);
        model_apply(ch, smp[ch]);
    endtask

    // One full scan; drop_ch < 0 means every channel answers.
    task automatic run_scan(input string tag, input int drop_ch,
                            input bit tick_mid);
        int d0 = done_cnt;
        int n0 = den_cnt;
        bit ok;
        bit got;
        @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        chk({tag, ".den_lat"}, drp.den, 1'b1);
        ok = drp.den;
        for (int ch = 0; ch < 4 && ok; ch++) begin
            if (ch > 0) begin
                wait_den(300, ok);
                chk({tag, ".den_seen"}, ok, 1'b1);
            end
            if (ok) begin
                chk({tag, ".daddr"}, drp.daddr, addr_tab[ch]);
                if (ch == drop_ch) m_to = 1;
                else respond(ch, $urandom_range(1, 4), tick_mid && ch == 1);
            end
        end
        got = 0;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk);
            #1;
            if (done_cnt != d0) got = 1;
        end
        repeat (3) @(negedge clk);
        #1;
        chk({tag, ".done_cnt"}, done_cnt - d0, 1);
        chk({tag, ".den_cnt"}, den_cnt - n0, 4);
        check_flags(tag);
    endtask

    function automatic logic [11:0] pick_sample();
        logic [11:0] edges[13] = '{12'h000, 12'h3FF, 12'h400, 12'h401,
                                   12'h5FF, 12'h600, 12'h601, 12'h9FF,
                                   12'hA00, 12'hA01, 12'hBFF, 12'hC00,
                                   12'hFFF};
        if ($urandom_range(0, 1) == 0) return edges[$urandom_range(0, 12)];
        return 12'($urandom);
    endfunction

    initial begin
        bit ok;
        int n0;
        logic [11:0] hyst[5] = '{12'h300, 12'h500, 12'h600,
                                 12'hB00, 12'hC00};
        addr_tab[0] = 7'h16;
        addr_tab[1] = 7'h1E;
        addr_tab[2] = 7'h17;
        addr_tab[3] = 7'h1F;
        drp.drdy = 1'b0;
        drp.do_data = 16'h0;
        model_reset();

        #1;
        chk("rst.den", drp.den, 1'b0);
        chk("rst.daddr", drp.daddr, 7'h16);
        chk("rst.scan_done", scan_done, 1'b0);
        check_flags("rst");
        repeat (2) @(negedge clk);
        reset = 1'b1;

        smp[0] = 12'h000; smp[1] = 12'hFFF;
        smp[2] = 12'h800; smp[3] = 12'h800;
        run_scan("basic", -1, 0);
        run_scan("basic2", -1, 0);

        for (int k = 0; k < 5; k++) begin
            smp[0] = hyst[k];
            run_scan("hyst", -1, 0);
        end

        smp[2] = 12'h000; smp[3] = 12'hFFF;
        run_scan("pre_to", -1, 0);
        run_scan("pre_to2", -1, 0);
        smp[2] = 12'hFFF;
        run_scan("to", 2, 0);
        smp[2] = 12'h800;
        run_scan("to_sticky", -1, 0);

        // Stray drdy while idle must not touch the flags.
        @(negedge clk);
        drp.drdy = 1'b1;
        drp.do_data = 16'h0000;
        repeat (2) @(negedge clk);
        drp.drdy = 1'b0;
        #1;
        check_flags("stray");

        run_scan("mid_tick", -1, 1);
        n0 = den_cnt;
        repeat (10) @(negedge clk);
        #1;
        chk("mid_tick.idle_den", den_cnt - n0, 0);

        // Reset asserted during the WAIT of channel 1.
        @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        respond(0, 1, 0);
        wait_den(20, ok);
        chk("rst_mid.den_seen", ok, 1'b1);
        chk("rst_mid.daddr1", drp.daddr, 7'h1E);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        chk("rst_mid.den", drp.den, 1'b0);
        chk("rst_mid.daddr", drp.daddr, 7'h16);
        check_flags("rst_mid");
        @(negedge clk);
        reset = 1'b1;
        run_scan("after_rst", -1, 0);

        for (int k = 0; k < 40; k++) begin
            for (int c = 0; c < 4; c++) smp[c] = pick_sample();
            run_scan("rand", ($urandom_range(0, 9) == 0) ?
                     int'($urandom_range(0, 3)) : -1, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/joystick_scanner.md
Name: joystick_scanner

Overview:
- Replaces the ad-hoc vsync-clocked joystick sampling with a single-clock XADC DRP read sequencer plus direction decoder.
- Sits between the XADC wizard (DRP port) and gameLogic; drives right/left/up/down for two players.
- Once per frame tick, reads four auxiliary channels in a fixed order, classifies each 12-bit sample with hysteresis, and updates registered move flags.

Parameters:
- CH0_ADDR, 7'h16, DRP address of P1 vertical axis
- CH1_ADDR, 7'h1E, DRP address of P1 horizontal axis
- CH2_ADDR, 7'h17, DRP address of P2 vertical axis
- CH3_ADDR, 7'h1F, DRP address of P2 horizontal axis
- LO_ON, 12'h400, sample <= this asserts low direction (up/left)
- LO_OFF, 12'h600, sample >= this releases low direction
- HI_ON, 12'hC00, sample >= this asserts high direction (down/right)
- HI_OFF, 12'hA00, sample <= this releases high direction
- TIMEOUT_CYCLES, 255, max cycles waiting for drdy per read

Ports:
- clk  in  1  system clock (100 MHz); also drives XADC dclk_in
- reset  in  1  asynchronous, active-low reset
- frame_tick  in  1  single-cycle scan request (synchronous pulse, one per frame)
- daddr  out  7  DRP address to XADC
- den  out  1  DRP enable, single-cycle pulse
- drdy  in  1  DRP data valid
- do_data  in  16  DRP read data; sample = do_data[15:4]
- p1_up, p1_down, p1_left, p1_right  out  1 each  player 1 move flags
- p2_up, p2_down, p2_left, p2_right  out  1 each  player 2 move flags
- scan_done  out  1  one-cycle pulse after channel 3 is processed
- timeout_err  out  1  sticky flag: a drdy timeout occurred

Behaviour:
- Reset (reset=0, async): all move flags 0, den 0, daddr CH0_ADDR, scan_done 0, timeout_err 0, FSM IDLE, channel index 0, timeout counter 0.
- FSM states: IDLE, ISSUE, WAIT, UPDATE.
- IDLE: on frame_tick=1, go to ISSUE with idx=0. frame_tick in any other state is ignored (no queuing).
- ISSUE: daddr = address[idx] held from this cycle until leaving WAIT; den=1 for exactly this cycle; clear timeout counter; go to WAIT.
- WAIT:
  - drdy=1: capture do_data[15:4]; go to UPDATE.
  - Otherwise increment counter. When counter reaches TIMEOUT_CYCLES: set timeout_err, leave that channel's flags unchanged, go to UPDATE with no sample.
  - drdy arriving in the same cycle the counter reaches TIMEOUT_CYCLES counts as success.
- UPDATE: apply the decode below if a sample was captured. If idx==3, pulse scan_done and return to IDLE; else increment idx and go to ISSUE.
- Latency: den rises 1 cycle after frame_tick. A full scan with immediate drdy takes 4 x (ISSUE + WAIT + UPDATE) = 12 cycles from ISSUE to the scan_done cycle.
- Decode per axis (vertical: low = up, high = down; horizontal: low = left, high = right):
  - low flag sets when s <= LO_ON, clears when s >= LO_OFF, otherwise holds.
  - high flag sets when s >= HI_ON, clears when s <= HI_OFF, otherwise holds.
  - Low and high flags of one axis are never both 1: if one sets, the other clears that same cycle.
- Move flags update only in UPDATE and are registered.
- Reset mid-scan aborts immediately to the reset state; the next scan starts from idx 0.
- drdy asserted outside WAIT is ignored.
- Unsigned 12-bit compares throughout.

Optional Feature:
- Macro: JOYSTICK_SCANNER_DEBOUNCE_EN.
- Defined: a flag changes only when two consecutive scans both classify the axis the same way.
  - Adds one 2-bit pending-direction register per axis.
  - A timeout scan does not count and does not clear the pending state.
- Undefined: flags update on every successful sample; no pending registers are built.

Test Plan:
- Reset then frame_tick, drdy returned 2 cycles after each den, samples 12'h000, 12'hFFF, 12'h800, 12'h800 -> daddr sequence 16, 1E, 17, 1F; p1_up=1, p1_right=1, all P2 flags 0; scan_done pulses once; timeout_err=0.
- Hysteresis on channel 0 across scans: 12'h300 -> p1_up=1; 12'h500 -> stays 1; 12'h600 -> 0; 12'hB00 -> p1_down stays 0; 12'hC00 -> p1_down=1.
- Channel 2 never returns drdy -> after 255 wait cycles timeout_err=1 sticky; P2 vertical flags retain their prior values; channels 3 and onward still read; scan_done pulses.
- frame_tick repeated mid-scan -> ignored; exactly one scan_done; next frame_tick after IDLE starts a new scan at CH0.
- reset pulsed low during WAIT of channel 1 -> den=0 and all flags 0 immediately (no clock edge needed); next frame_tick reads from 7'h16.
- With JOYSTICK_SCANNER_DEBOUNCE_EN defined: channel 1 sample 12'hFFF on one scan -> p1_right stays 0; the same sample on the next scan -> p1_right=1.
